iopmp_scan_checker: RTL and testbench

Parametrised successor to the single-cycle IOPMP rule checker. It accepts one DMA access request at a time over a valid/ready handshake and scans the entry table ENTRIES_PER_CYCLE entries per cycle in priority order. It returns an allow/deny response over a second valid/ready handshake and keeps a sticky violation record with an interrupt and an overflow counter. It sits between the DMA master port and the bus. Configuration comes from the IOPMP register file as flat vectors.

---
 rtl/iopmp_scan_checker.sv | 274 +++++++++++++++++++++++++++
 tb/tb_iopmp_scan_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iopmp_scan_checker.sv
`default_nettype none
// ============================================================================
// Module   : iopmp_scan_checker
// Brief    : Multi-cycle IOPMP checker. Scans ENTRIES_PER_CYCLE entries per
//            cycle in priority order and keeps a sticky violation record.
//            Optional macro IOPMP_PERF_CNT_EN adds allow/deny response counters.
// Revision : 1.0 - initial release
// ============================================================================
module iopmp_scan_checker #(
  parameter int PLEN              = 34,
  parameter int NR_SID            = 4,
  parameter int NR_MD             = 4,
  parameter int NR_ENTRIES        = 16,
  parameter int ENTRIES_PER_CYCLE = 4,
  localparam int SID_W = (NR_SID > 1) ? $clog2(NR_SID) : 1,
  localparam int IDX_W = $clog2(NR_ENTRIES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [NR_ENTRIES*PLEN-1:0] entry_base_i,
  input  logic [NR_ENTRIES*PLEN-1:0] entry_top_i,
  input  logic [NR_ENTRIES*4-1:0]  entry_cfg_i,
  input  logic [NR_SID*NR_MD-1:0]  srcmd_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [PLEN-1:0]          req_addr_i,
  input  logic [SID_W-1:0]         req_sid_i,
  input  logic                     req_write_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_allow_o,
  output logic                     rec_valid_o,
  output logic [PLEN-1:0]          rec_addr_o,
  output logic [SID_W-1:0]         rec_sid_o,
  output logic                     rec_write_o,
  output logic [IDX_W-1:0]         rec_entry_o,
  output logic [7:0]               rec_ovf_o,
  input  logic                     rec_clear_i,
`ifdef IOPMP_PERF_CNT_EN
  output logic [31:0]              cnt_allow_o,
  output logic [31:0]              cnt_deny_o,
`endif
  output logic                     irq_o
);

  localparam int EPC     = ENTRIES_PER_CYCLE;
  localparam int NGROUPS = NR_ENTRIES / EPC;
  localparam int EPM     = NR_ENTRIES / NR_MD;
  localparam int GRP_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PLEN-1:0]    addr_q, addr_d;
  logic [SID_W-1:0]   sid_q, sid_d;
  logic               write_q, write_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic               allow_q, allow_d;

  logic               rec_valid_q, rec_valid_d;
  logic [PLEN-1:0]    rec_addr_q, rec_addr_d;
  logic [SID_W-1:0]   rec_sid_q, rec_sid_d;
  logic               rec_write_q, rec_write_d;
  logic [IDX_W-1:0]   rec_entry_q, rec_entry_d;
  logic               rec_irq_q, rec_irq_d;
  logic [7:0]         rec_ovf_q, rec_ovf_d;

  // Group 0 is evaluated on the live request in IDLE so a first-group hit
  // responds in the cycle right after acceptance.
  logic [PLEN-1:0]    ev_addr;
  logic [SID_W-1:0]   ev_sid;
  logic               ev_write;
  logic [GRP_W-1:0]   ev_grp;
  logic               hit, hit_allow, hit_irq;
  logic [IDX_W-1:0]   hit_idx;
  logic [PLEN-1:0]    e_base, e_top;
  logic [3:0]         e_cfg;
  logic               e_en;
  int                 e_idx, e_md;

  always_comb begin
    ev_addr   = (state_q == ST_IDLE) ? req_addr_i  : addr_q;
    ev_sid    = (state_q == ST_IDLE) ? req_sid_i   : sid_q;
    ev_write  = (state_q == ST_IDLE) ? req_write_i : write_q;
    ev_grp    = (state_q == ST_IDLE) ? '0 : grp_q;
    hit       = 1'b0;
    hit_allow = 1'b0;
    hit_irq   = 1'b0;
    hit_idx   = IDX_W'(NR_ENTRIES);
    e_base    = '0;
    e_top     = '0;
    e_cfg     = '0;
    e_en      = 1'b0;
    e_idx     = 0;
    e_md      = 0;
    for (int j = 0; j < EPC; j++) begin
      e_idx  = int'(ev_grp) * EPC + j;
      e_md   = e_idx / EPM;
      e_base = entry_base_i[e_idx*PLEN +: PLEN];
      e_top  = entry_top_i[e_idx*PLEN +: PLEN];
      e_cfg  = entry_cfg_i[e_idx*4 +: 4];
      e_en   = (int'(ev_sid) < NR_SID) ? srcmd_i[int'(ev_sid)*NR_MD + e_md] : 1'b0;
      if (!hit && e_cfg[0] && e_en && (e_base <= ev_addr) && (ev_addr < e_top)) begin
        hit       = 1'b1;
        hit_allow = ev_write ? e_cfg[2] : e_cfg[1];
        hit_irq   = e_cfg[3];
        hit_idx   = IDX_W'(e_idx);
      end
    end
  end

  logic             deny_ev;
  logic [IDX_W-1:0] deny_idx;
  logic             deny_irq;
  logic             scan_active;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sid_d    = sid_q;
    write_d  = write_q;
    grp_d    = grp_q;
    allow_d  = allow_q;
    deny_ev  = 1'b0;
    deny_idx = IDX_W'(NR_ENTRIES);
    deny_irq = 1'b1;
    scan_active = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          sid_d   = req_sid_i;
          write_d = req_write_i;
          grp_d   = '0;
          if (!enable_i) begin
            state_d = ST_RESP;
            allow_d = 1'b0;
            deny_ev = 1'b1;
          end else begin
            scan_active = 1'b1;
          end
        end
      end
      ST_SCAN: scan_active = 1'b1;
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (scan_active) begin
      if (hit) begin
        state_d  = ST_RESP;
        allow_d  = hit_allow;
        deny_ev  = !hit_allow;
        deny_idx = hit_idx;
        deny_irq = hit_irq;
      end else if (ev_grp == GRP_W'(NGROUPS - 1)) begin
        state_d = ST_RESP;
        allow_d = 1'b0;
        deny_ev = 1'b1;
      end else begin
        state_d = ST_SCAN;
        grp_d   = ev_grp + GRP_W'(1);
      end
    end
  end

  // The clear takes effect before a same-cycle deny is considered.
  logic       rv_after_clr;
  logic [7:0] ovf_after_clr;

  always_comb begin
    rv_after_clr  = rec_valid_q & ~rec_clear_i;
    ovf_after_clr = rec_clear_i ? 8'd0 : rec_ovf_q;
    rec_valid_d   = rv_after_clr;
    rec_ovf_d     = ovf_after_clr;
    rec_addr_d    = rec_clear_i ? '0 : rec_addr_q;
    rec_sid_d     = rec_clear_i ? '0 : rec_sid_q;
    rec_write_d   = rec_clear_i ? 1'b0 : rec_write_q;
    rec_entry_d   = rec_clear_i ? '0 : rec_entry_q;
    rec_irq_d     = rec_clear_i ? 1'b0 : rec_irq_q;
    if (deny_ev) begin
      if (!rv_after_clr) begin
        rec_valid_d = 1'b1;
        rec_addr_d  = ev_addr;
        rec_sid_d   = ev_sid;
        rec_write_d = ev_write;
        rec_entry_d = deny_idx;
        rec_irq_d   = deny_irq;
      end else if (ovf_after_clr != 8'hFF) begin
        rec_ovf_d = ovf_after_clr + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      sid_q       <= '0;
      write_q     <= 1'b0;
      grp_q       <= '0;
      allow_q     <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_addr_q  <= '0;
      rec_sid_q   <= '0;
      rec_write_q <= 1'b0;
      rec_entry_q <= '0;
      rec_irq_q   <= 1'b0;
      rec_ovf_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sid_q       <= sid_d;
      write_q     <= write_d;
      grp_q       <= grp_d;
      allow_q     <= allow_d;
      rec_valid_q <= rec_valid_d;
      rec_addr_q  <= rec_addr_d;
      rec_sid_q   <= rec_sid_d;
      rec_write_q <= rec_write_d;
      rec_entry_q <= rec_entry_d;
      rec_irq_q   <= rec_irq_d;
      rec_ovf_q   <= rec_ovf_d;
    end
  end

`ifdef IOPMP_PERF_CNT_EN
  logic [31:0] cnt_allow_q, cnt_allow_d;
  logic [31:0] cnt_deny_q, cnt_deny_d;

  always_comb begin
    cnt_allow_d = cnt_allow_q;
    cnt_deny_d  = cnt_deny_q;
    if (state_q == ST_RESP && rsp_ready_i) begin
      if (allow_q && cnt_allow_q != 32'hFFFF_FFFF) cnt_allow_d = cnt_allow_q + 32'd1;
      if (!allow_q && cnt_deny_q != 32'hFFFF_FFFF) cnt_deny_d = cnt_deny_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_allow_q <= '0;
      cnt_deny_q  <= '0;
    end else begin
      cnt_allow_q <= cnt_allow_d;
      cnt_deny_q  <= cnt_deny_d;
    end
  end

  assign cnt_allow_o = cnt_allow_q;
  assign cnt_deny_o  = cnt_deny_q;
`else
`endif

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_allow_o = (state_q == ST_RESP) & allow_q;
  assign rec_valid_o = rec_valid_q;
  assign rec_addr_o  = rec_addr_q;
  assign rec_sid_o   = rec_sid_q;
  assign rec_write_o = rec_write_q;
  assign rec_entry_o = rec_entry_q;
  assign rec_ovf_o   = rec_ovf_q;
  assign irq_o       = rec_valid_q & rec_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_iopmp_scan_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_iopmp_scan_checker
// Brief    : Directed self-checking bench for iopmp_scan_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iopmp_scan_checker;

  localparam int PLEN = 34;
  localparam int NE   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable_i = 1'b1;
  logic [NE*PLEN-1:0] entry_base = '0;
  logic [NE*PLEN-1:0] entry_top  = '0;
  logic [NE*4-1:0]   entry_cfg  = '0;
  logic [15:0]       srcmd = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [PLEN-1:0]   req_addr = '0;
  logic [1:0]        req_sid = '0;
  logic              req_write = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_allow;
  logic              rec_valid;
  logic [PLEN-1:0]   rec_addr;
  logic [1:0]        rec_sid;
  logic              rec_write;
  logic [4:0]        rec_entry;
  logic [7:0]        rec_ovf;
  logic              rec_clear = 1'b0;
  logic              irq;
`ifdef IOPMP_PERF_CNT_EN
  logic [31:0]       cnt_allow;
  logic [31:0]       cnt_deny;
`endif

  int errors = 0;
  int checks = 0;
  int lat;

  iopmp_scan_checker dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable_i),
    .entry_base_i (entry_base),
    .entry_top_i  (entry_top),
    .entry_cfg_i  (entry_cfg),
    .srcmd_i      (srcmd),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_sid_i    (req_sid),
    .req_write_i  (req_write),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_allow_o  (rsp_allow),
    .rec_valid_o  (rec_valid),
    .rec_addr_o   (rec_addr),
    .rec_sid_o    (rec_sid),
    .rec_write_o  (rec_write),
    .rec_entry_o  (rec_entry),
    .rec_ovf_o    (rec_ovf),
    .rec_clear_i  (rec_clear),
`ifdef IOPMP_PERF_CNT_EN
    .cnt_allow_o  (cnt_allow),
    .cnt_deny_o   (cnt_deny),
`endif
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int i, input logic [PLEN-1:0] b, input logic [PLEN-1:0] t,
                           input logic [3:0] c);
    entry_base[i*PLEN +: PLEN] = b;
    entry_top[i*PLEN +: PLEN]  = t;
    entry_cfg[i*4 +: 4]        = c;
  endtask

  // Issues one request (optionally with a same-cycle clear) and measures the
  // number of cycles from the acceptance edge until rsp_valid is seen.
  task automatic issue(input logic [PLEN-1:0] a, input logic [1:0] s, input logic w,
                       input logic clr, output int l);
    req_addr  = a;
    req_sid   = s;
    req_write = w;
    req_valid = 1'b1;
    rec_clear = clr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rec_clear = 1'b0;
    l = 1;
    while (!rsp_valid && l < 16) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("idle_after_hs_ready", {63'd0, req_ready}, 64'd1);
    check("idle_after_hs_valid", {63'd0, rsp_valid}, 64'd0);
  endtask

  task automatic clear_pulse();
    rec_clear = 1'b1;
    @(posedge clk); #1;
    rec_clear = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_allow", {63'd0, rsp_allow}, 64'd0);
    check("rst_rec_valid", {63'd0, rec_valid}, 64'd0);
    check("rst_rec_entry", {59'd0, rec_entry}, 64'd0);
    check("rst_rec_ovf", {56'd0, rec_ovf}, 64'd0);
    check("rst_irq", {63'd0, irq}, 64'd0);

    // Entry0: valid+R+irq, MD0; SID1 enabled for MD0
    set_entry(0, 34'h1000, 34'h2000, 4'b1011);
    srcmd[1*4+0] = 1'b1;
    issue(34'h1800, 2'd1, 1'b0, 1'b0, lat);
    check("t1_lat", 64'(lat), 64'd1);
    check("t1_allow", {63'd0, rsp_allow}, 64'd1);
    check("t1_rec_valid", {63'd0, rec_valid}, 64'd0);
    finish_rsp();

    issue(34'h1800, 2'd1, 1'b1, 1'b0, lat);
    check("t2_lat", 64'(lat), 64'd1);
    check("t2_allow", {63'd0, rsp_allow}, 64'd0);
    check("t2_rec_valid", {63'd0, rec_valid}, 64'd1);
    check("t2_rec_addr", {30'd0, rec_addr}, 64'h1800);
    check("t2_rec_sid", {62'd0, rec_sid}, 64'd1);
    check("t2_rec_write", {63'd0, rec_write}, 64'd1);
    check("t2_rec_entry", {59'd0, rec_entry}, 64'd0);
    check("t2_irq", {63'd0, irq}, 64'd1);
    finish_rsp();
    clear_pulse();
    check("t2_clear_valid", {63'd0, rec_valid}, 64'd0);
    check("t2_clear_irq", {63'd0, irq}, 64'd0);

    // Entry13 (MD3) R+W; SID0 enabled for MD3 -> decided in group 3
    set_entry(13, 34'h8000, 34'h9000, 4'b0111);
    srcmd[0*4+3] = 1'b1;
    issue(34'h8000, 2'd0, 1'b0, 1'b0, lat);
    check("t3_lat", 64'(lat), 64'd4);
    check("t3_allow", {63'd0, rsp_allow}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("t3_hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("t3_hold_allow", {63'd0, rsp_allow}, 64'd1);
      check("t3_hold_ready", {63'd0, req_ready}, 64'd0);
    end
    finish_rsp();

    // Entry2 (MD0, R only) shadows entry9 (MD2, R+W) unless SID lacks MD0
    set_entry(2, 34'h3000, 34'h4000, 4'b0011);
    set_entry(9, 34'h3000, 34'h4000, 4'b0111);
    srcmd[2*4+2] = 1'b1;
    issue(34'h3000, 2'd2, 1'b1, 1'b0, lat);
    check("t4_lat", 64'(lat), 64'd3);
    check("t4_allow", {63'd0, rsp_allow}, 64'd1);
    finish_rsp();

    // Top is exclusive: full-scan miss, forced irq
    issue(34'h9000, 2'd0, 1'b0, 1'b0, lat);
    check("miss_lat", 64'(lat), 64'd4);
    check("miss_allow", {63'd0, rsp_allow}, 64'd0);
    check("miss_rec_entry", {59'd0, rec_entry}, 64'd16);
    check("miss_rec_addr", {30'd0, rec_addr}, 64'h9000);
    check("miss_irq", {63'd0, irq}, 64'd1);
    finish_rsp();

    issue(34'h1800, 2'd1, 1'b1, 1'b0, lat);
    check("t5_lat2", 64'(lat), 64'd1);
    check("t5_keep_addr", {30'd0, rec_addr}, 64'h9000);
    check("t5_ovf1", {56'd0, rec_ovf}, 64'd1);
    finish_rsp();

    issue(34'h1abc, 2'd1, 1'b1, 1'b1, lat);
    check("t5_clr_valid", {63'd0, rec_valid}, 64'd1);
    check("t5_clr_addr", {30'd0, rec_addr}, 64'h1abc);
    check("t5_clr_entry", {59'd0, rec_entry}, 64'd0);
    check("t5_clr_write", {63'd0, rec_write}, 64'd1);
    check("t5_clr_ovf", {56'd0, rec_ovf}, 64'd0);
    finish_rsp();

    clear_pulse();
    enable_i = 1'b0;
    issue(34'h1800, 2'd1, 1'b0, 1'b0, lat);
    check("dis_lat", 64'(lat), 64'd1);
    check("dis_allow", {63'd0, rsp_allow}, 64'd0);
    check("dis_rec_entry", {59'd0, rec_entry}, 64'd16);
    check("dis_irq", {63'd0, irq}, 64'd1);
    finish_rsp();
    for (int k = 0; k < 260; k++) begin
      issue(34'h1800, 2'd1, 1'b0, 1'b0, lat);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
    check("ovf_saturate", {56'd0, rec_ovf}, 64'd255);
    enable_i = 1'b1;

    // Reset during SCAN drops the transaction
    issue_no_wait();
    check("t6_in_scan", {63'd0, req_ready}, 64'd0);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {63'd0, rsp_valid}, 64'd0);
    check("t6_rst_ready", {63'd0, req_ready}, 64'd1);
    check("t6_rst_rec", {63'd0, rec_valid}, 64'd0);
    check("t6_rst_ovf", {56'd0, rec_ovf}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(34'h1800, 2'd1, 1'b0, 1'b0, lat);
    check("t6_after_lat", 64'(lat), 64'd1);
    check("t6_after_allow", {63'd0, rsp_allow}, 64'd1);
    finish_rsp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic issue_no_wait();
    req_addr  = 34'h8000;
    req_sid   = 2'd0;
    req_write = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

endmodule
`default_nettype wire
